mul_div_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit for the MIPS core. It executes MULT, MULTU, DIV and DIVU, which the single-cycle ALU does not handle.
- Results go to architectural HI/LO registers held inside this block. The block also serves MTHI and MTLO writes.
- It sits beside the ALU in EX. The pipeline issues an operation with a start pulse and stalls on busy.

---
 rtl/mul_div_unit.sv | 156 +++++++++++++++
 tb/tb_mul_div_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Shift-add multiply and restoring divide, one bit per clock, 33-clock latency.
// Optional build macro MUL_DIV_EARLY_OUT_EN: a multiply finishes as soon as the
// remaining multiplier bits are all zero. Divide timing is unaffected.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [1:0]             op_reg;
    logic                   sign_a_reg;   // dividend/multiplicand negative (signed ops only)
    logic                   neg_reg;      // result (product or quotient) must be negated
    logic                   dz_reg;       // divide with a zero divisor
    logic [2*WIDTH-1:0]     mcand_reg;    // multiplicand (shifting) or divisor in low half
    logic [WIDTH-1:0]       shr_reg;      // multiplier (shifting right) or dividend/quotient
    logic [2*WIDTH-1:0]     acc_reg;      // product accumulator or remainder in low WIDTH+1 bits
    logic [WIDTH-1:0]       hi_reg, lo_reg;

    logic                   accept;
    logic                   last_iter;
    logic                   mul_early;
    logic                   op_signed;
    logic [WIDTH-1:0]       abs_a, abs_b;
    logic [2*WIDTH-1:0]     acc_add;
    logic [WIDTH:0]         rem_shift;
    logic [WIDTH+1:0]       diff;
    logic                   fits;
    logic [WIDTH:0]         rem_new;
    logic [WIDTH-1:0]       q_new;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       q_fix, r_fix;
    logic [WIDTH-1:0]       res_hi, res_lo;

    assign accept    = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

    // Operand magnitudes: op[0]=0 selects the signed variants.
    assign op_signed = ~op[0];
    assign abs_a     = (op_signed && A[WIDTH-1]) ? -A : A;
    assign abs_b     = (op_signed && B[WIDTH-1]) ? -B : B;

    // One shift-add multiply step.
    assign acc_add = shr_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    // One restoring-divide step: bring down the next dividend bit, trial subtract.
    assign rem_shift = {acc_reg[WIDTH-1:0], shr_reg[WIDTH-1]};
    assign diff      = {1'b0, rem_shift} - {2'b00, mcand_reg[WIDTH-1:0]};
    assign fits      = ~diff[WIDTH+1];
    assign rem_new   = fits ? diff[WIDTH:0] : rem_shift;
    assign q_new     = {shr_reg[WIDTH-2:0], fits};

`ifdef MUL_DIV_EARLY_OUT_EN
    // Multiply can stop once the multiplier left after this step is zero.
    assign mul_early = ~op_reg[1] && (shr_reg[WIDTH-1:1] == '0);
`else
    assign mul_early = 1'b0;
`endif

    // Sign correction applied in FIX; a zero divisor forces an all-ones quotient.
    assign prod_fix = neg_reg ? -acc_reg : acc_reg;
    assign q_fix    = dz_reg ? '1 : (neg_reg ? -shr_reg : shr_reg);
    assign r_fix    = sign_a_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign res_hi   = op_reg[1] ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = op_reg[1] ? q_fix : prod_fix[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = CALC;
            CALC: if (last_iter || mul_early) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, iterate one bit per clock in CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            op_reg     <= '0;
            sign_a_reg <= 1'b0;
            neg_reg    <= 1'b0;
            dz_reg     <= 1'b0;
            mcand_reg  <= '0;
            shr_reg    <= '0;
            acc_reg    <= '0;
        end else if (accept) begin
            cnt_reg    <= '0;
            op_reg     <= op;
            sign_a_reg <= op_signed & A[WIDTH-1];
            neg_reg    <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            dz_reg     <= op[1] && (B == '0);
            mcand_reg  <= {{WIDTH{1'b0}}, (op[1] ? abs_b : abs_a)};
            shr_reg    <= op[1] ? abs_a : abs_b;
            acc_reg    <= '0;
        end else if (state_reg == CALC) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (op_reg[1]) begin
                acc_reg <= {{(WIDTH-1){1'b0}}, rem_new};
                shr_reg <= q_new;
            end else begin
                acc_reg   <= acc_add;
                mcand_reg <= {mcand_reg[2*WIDTH-2:0], 1'b0};
                shr_reg   <= {1'b0, shr_reg[WIDTH-1:1]};
            end
        end
    end

    // HI/LO: result write in FIX has priority; MTHI/MTLO only while not busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state_reg == FIX) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
        end else if (!busy) begin
            if (hi_we) hi_reg <= wdata;
            if (lo_we) lo_reg <= wdata;
        end
    end

    assign busy        = (state_reg == CALC) || (state_reg == FIX);
    assign done        = (state_reg == DONE);
    assign div_by_zero = done & dz_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized + directed bench for mul_div_unit, checked every
// cycle against a plain-arithmetic reference model of HI/LO, busy and done.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] A = '0, B = '0;
    logic         hi_we = 1'b0, lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Expectation table written by the driver, consumed by the compare process.
    logic [W-1:0] exp_hi  [256];
    logic [W-1:0] exp_lo  [256];
    logic         exp_dz  [256];
    logic [1:0]   exp_op  [256];
    logic [W-1:0] exp_a   [256];
    logic [W-1:0] exp_b   [256];
    int           exp_done[256];
    int n_issued  = 0;
    int n_checked = 0;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    int last_done = 0;

    // Reference result from plain signed/unsigned arithmetic.
    function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        case (o)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'd0, a} * {32'd0, b};
            default: p = '0;
        endcase
        h = p[63:32];
        l = p[31:0];
        if (o[1]) begin
            if (b == '0) begin
                dz = 1'b1;
                l  = '1;
                h  = a;
            end else if (o[0]) begin
                l = a / b;
                h = a % b;
            end else begin
                q = sa / sb;
                r = sa % sb;
                l = q[31:0];
                h = r[31:0];
            end
        end
    endfunction

    // Clocks from the start edge to the edge after which done is visible.
    function automatic int ref_lat(input logic [1:0] o, input logic [W-1:0] b);
        int lat;
        lat = 33;
`ifdef MUL_DIV_EARLY_OUT_EN
        if (!o[1]) begin
            logic [W-1:0] m;
            int bl;
            m  = (!o[0] && b[W-1]) ? -b : b;
            bl = 1;
            for (int i = 0; i < W; i++) if (m[i]) bl = i + 1;
            lat = bl + 1;
        end
`endif
        return lat;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Hand-computed values that pin the reference model itself.
    task automatic pin_model();
        logic [W-1:0] h, l;
        logic dz;
        ref_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, h, l, dz);
        chk("pin_multu_hi", h, 32'hFFFFFFFE); chk("pin_multu_lo", l, 32'h00000001);
        ref_op(2'b00, 32'hFFFFFFFD, 32'd7, h, l, dz);
        chk("pin_mult_hi", h, 32'hFFFFFFFF); chk("pin_mult_lo", l, 32'hFFFFFFEB);
        ref_op(2'b10, 32'hFFFFFFF9, 32'd2, h, l, dz);
        chk("pin_div_hi", h, 32'hFFFFFFFF); chk("pin_div_lo", l, 32'hFFFFFFFD);
        ref_op(2'b11, 32'd100, 32'd7, h, l, dz);
        chk("pin_divu_hi", h, 32'd2); chk("pin_divu_lo", l, 32'd14);
        ref_op(2'b11, 32'd5, 32'd0, h, l, dz);
        chk("pin_dz_hi", h, 32'd5); chk("pin_dz_lo", l, 32'hFFFFFFFF); chk("pin_dz_flag", W'(dz), 32'd1);
        ref_op(2'b10, 32'h80000000, 32'hFFFFFFFF, h, l, dz);
        chk("pin_ovf_hi", h, 32'd0); chk("pin_ovf_lo", l, 32'h80000000); chk("pin_ovf_dz", W'(dz), 32'd0);
`ifdef MUL_DIV_EARLY_OUT_EN
        chk("pin_lat_5x3", W'(ref_lat(2'b01, 32'd3)), 32'd3);
        chk("pin_lat_9x0", W'(ref_lat(2'b01, 32'd0)), 32'd2);
        chk("pin_lat_div", W'(ref_lat(2'b11, 32'd0)), 32'd33);
`else
        chk("pin_lat_multu", W'(ref_lat(2'b01, 32'hFFFFFFFF)), 32'd33);
        chk("pin_lat_mult0", W'(ref_lat(2'b00, 32'd0)), 32'd33);
`endif
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        bit outstanding, mb, md;
        cyc = cyc + 1;
        if (cyc == 2) pin_model();
        if (rst) begin
            n_checked = n_issued;
            m_hi = '0;
            m_lo = '0;
            chk("rst_busy", W'(busy), '0);
            chk("rst_done", W'(done), '0);
            chk("rst_dz", W'(div_by_zero), '0);
            chk("rst_hi", hi, '0);
            chk("rst_lo", lo, '0);
        end else begin
            outstanding = (n_checked < n_issued);
            mb = outstanding && (cyc < exp_done[n_checked]);
            md = outstanding && (cyc == exp_done[n_checked]);
            chk("busy", W'(busy), W'(mb));
            chk("done", W'(done), W'(md));
            if (md) begin
                chk("res_hi", hi, exp_hi[n_checked]);
                chk("res_lo", lo, exp_lo[n_checked]);
                chk("res_dz", W'(div_by_zero), W'(exp_dz[n_checked]));
                $display("[TB] op=%0d A=%h B=%h -> hi=%h lo=%h dz=%0d", exp_op[n_checked],
                         exp_a[n_checked], exp_b[n_checked], hi, lo, div_by_zero);
                m_hi = exp_hi[n_checked];
                m_lo = exp_lo[n_checked];
                n_checked = n_checked + 1;
            end else begin
                chk("hold_hi", hi, m_hi);
                chk("hold_lo", lo, m_lo);
            end
            if (!mb) begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
            end
        end
    end

    // Issue one operation; caller is just after a clock edge with the unit free.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] h, l;
        logic dz;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        ref_op(o, a, b, h, l, dz);
        exp_hi[n_issued] = h; exp_lo[n_issued] = l; exp_dz[n_issued] = dz;
        exp_op[n_issued] = o; exp_a[n_issued] = a; exp_b[n_issued] = b;
        exp_done[n_issued] = cyc + ref_lat(o, b) + 1;
        last_done = exp_done[n_issued];
        n_issued = n_issued + 1;
        #1;
        start = 1'b0;
    endtask

    // Advance to just after the edge that makes done visible (the DONE cycle).
    task automatic wait_done();
        while (cyc < last_done - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);

        // Directed cases.
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_done(); tick(1);
        run_op(2'b00, 32'hFFFFFFFD, 32'd7);        wait_done(); tick(1);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2);        wait_done();
        run_op(2'b11, 32'd100, 32'd7);             wait_done(); tick(1);
        run_op(2'b11, 32'd5, 32'd0);               wait_done(); tick(1);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF); wait_done(); tick(1);
        run_op(2'b01, 32'd5, 32'd3);               wait_done(); tick(1);
        run_op(2'b01, 32'd9, 32'd0);               wait_done(); tick(1);

        // MTHI/MTLO while idle.
        hi_we = 1'b1; wdata = 32'h12345678; tick(1);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABCDEF0; tick(1);
        lo_we = 1'b0; tick(1);

        // start and lo_we while busy are ignored.
        run_op(2'b01, 32'd3, 32'd4);
        tick(1);
        start = 1'b1; op = 2'b11; A = 32'd77; B = 32'd5;
        lo_we = 1'b1; wdata = 32'hDEADBEEF;
        tick(1);
        start = 1'b0; lo_we = 1'b0;
        wait_done(); tick(1);

        // Reset ten clocks into a divide aborts it.
        run_op(2'b10, 32'h7FFFFFFF, 32'd3);
        tick(9);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(40);

        // Random operations, random gaps, back-to-back starts and MTHI/MTLO.
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick());
            wait_done();
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = W'($urandom);
                end
                tick(1);
                hi_we = 1'b0; lo_we = 1'b0;
                tick($urandom_range(0, 2));
            end
        end

        tick(40);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
